clock_cfg_tx: RTL and testbench

Serial configuration transmitter for the slow-clock generator. It accepts a 32-bit clock half-period count over a valid/ready handshake and serialises it onto the `clock_change_mode` / `clock_max_count` pair, one bit per `fastClk` cycle, LSB first. It sits between the front-panel/control logic and the `clock` block, and both share `fastClk` and `rst`.

---
 rtl/clock_cfg_pkg.sv | 14 +
 rtl/clock_cfg_tx_if.sv | 33 +++
 rtl/clock_cfg_tx.sv | 134 +++++++++++++
 tb/tb_clock_cfg_tx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/clock_cfg_pkg.sv
// Shared definitions for the slow-clock configuration link (transmitter and receiver).
package clock_cfg_pkg;

    localparam int CLK_CFG_W     = 32;
    localparam int CLK_CFG_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SHIFT,
        GAP
    } clock_cfg_state_t;

endpackage

// File: rtl/clock_cfg_tx_if.sv
// Bundle of the configuration handshake and the serial link toward the clock block.
interface clock_cfg_tx_if;
    import clock_cfg_pkg::*;

    logic [CLK_CFG_W-1:0] cfg_data;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic                 clock_change_mode;
    logic                 clock_max_count;
    logic                 busy;
    logic                 done;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready,
        input  clock_change_mode,
        input  clock_max_count,
        input  busy,
        input  done
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready,
        output clock_change_mode,
        output clock_max_count,
        output busy,
        output done
    );

endinterface

// File: rtl/clock_cfg_tx.sv
// Serialises a 32-bit half-period count LSB first behind a one-cycle sync marker.
// Optional macro CLOCK_CFG_TX_SKIP_SAME_EN drops values equal to the last one sent.
module clock_cfg_tx
    import clock_cfg_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic           fastClk,
    input  logic           rst,
    clock_cfg_tx_if.slave  cfg_if
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CLK_CFG_IDX_W-1:0] IDX_LAST = '1;

    clock_cfg_state_t           state_q, state_d;
    logic [CLK_CFG_W-1:0]       shift_q, shift_d;
    logic [CLK_CFG_IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic                       mode_q, mode_d;
    logic                       bit_q, bit_d;
    logic                       done_q, done_d;
    logic                       skip_hit;

`ifdef CLOCK_CFG_TX_SKIP_SAME_EN
    logic [CLK_CFG_W-1:0]       last_sent_q, last_sent_d;

    // Reset value 0 matches the receiver's reset maxCount.
    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            last_sent_q <= '0;
        end else begin
            last_sent_q <= last_sent_d;
        end
    end

    assign skip_hit = (cfg_if.cfg_data == last_sent_q);
`else
    assign skip_hit = 1'b0;
`endif

    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            mode_q  <= 1'b0;
            bit_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            mode_q  <= mode_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
        end
    end

    // Outputs are computed one cycle ahead so the serial pair comes straight from flops.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        mode_d  = 1'b0;
        bit_d   = 1'b0;
        done_d  = 1'b0;
`ifdef CLOCK_CFG_TX_SKIP_SAME_EN
        last_sent_d = last_sent_q;
`endif

        case (state_q)
            IDLE: begin
                if (cfg_if.cfg_valid) begin
                    if (skip_hit) begin
                        done_d = 1'b1;
                    end else begin
                        shift_d = cfg_if.cfg_data;
                        idx_d   = '0;
                        state_d = SYNC;
                        mode_d  = 1'b1;
`ifdef CLOCK_CFG_TX_SKIP_SAME_EN
                        last_sent_d = cfg_if.cfg_data;
`endif
                    end
                end
            end

            SYNC: begin
                state_d = SHIFT;
                mode_d  = 1'b1;
                bit_d   = shift_q[0];
                shift_d = shift_q >> 1;
            end

            SHIFT: begin
                // Index wraps 31 -> 0 on the last bit; that is the normal exit.
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                    gap_d   = GAP_LOAD;
                end else begin
                    mode_d  = 1'b1;
                    bit_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end

            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg_if.cfg_ready         = (state_q == IDLE);
    assign cfg_if.busy              = (state_q != IDLE);
    assign cfg_if.clock_change_mode = mode_q;
    assign cfg_if.clock_max_count   = bit_q;
    assign cfg_if.done              = done_q;

endmodule

// File: tb/tb_clock_cfg_tx.sv
// Directed and randomized checks of clock_cfg_tx against a cycle-offset frame model.
module tb_clock_cfg_tx;

    localparam int GAP = 2;

    logic fastClk = 1'b0;
    logic rst     = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    logic [31:0] last_sent_m = 32'h0;

    clock_cfg_tx_if bus ();

    clock_cfg_tx #(.GAP_CYCLES(GAP)) dut (
        .fastClk (fastClk),
        .rst     (rst),
        .cfg_if  (bus.slave)
    );

    always #5 fastClk = ~fastClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_mode"},  32'(bus.clock_change_mode), 32'h0);
        chk({tag, "_bit"},   32'(bus.clock_max_count),   32'h0);
        chk({tag, "_busy"},  32'(bus.busy),              32'h0);
        chk({tag, "_done"},  32'(bus.done),              32'h0);
        chk({tag, "_ready"}, 32'(bus.cfg_ready),         32'h1);
    endtask

    // Waits for acceptance; returns at the negedge of cycle T with ready high.
    task automatic wait_accept(input logic [31:0] val);
        int w;
        bus.cfg_data  = val;
        bus.cfg_valid = 1'b1;
        w = 0;
        while (!bus.cfg_ready && w < 200) begin
            @(negedge fastClk);
            w++;
        end
        chk("accept_ready", 32'(bus.cfg_ready), 32'h1);
    endtask

    // Model: frame occupies T+1..T+33 (sync then bits 0..31), done at T+34, ready at T+34+GAP.
    task automatic send(input logic [31:0] val, input bit hold,
                        input bit alt_en, input logic [31:0] alt_val);
        bit          skip;
        logic [31:0] recon;
        int          last_k;
        wait_accept(val);
        skip = 1'b0;
`ifdef CLOCK_CFG_TX_SKIP_SAME_EN
        skip = (val == last_sent_m);
`endif
        if (!skip) last_sent_m = val;
        @(negedge fastClk);
        if (!hold) bus.cfg_valid = 1'b0;
        if (skip) begin
            chk("skip_done",  32'(bus.done),              32'h1);
            chk("skip_mode",  32'(bus.clock_change_mode), 32'h0);
            chk("skip_ready", 32'(bus.cfg_ready),         32'h1);
            chk("skip_busy",  32'(bus.busy),              32'h0);
            $display("tx value=%h skipped", val);
            return;
        end
        recon  = 32'h0;
        last_k = 34 + GAP;
        for (int k = 1; k <= last_k; k++) begin
            if (alt_en && k == 10) bus.cfg_data = alt_val;
            chk("frame_mode",  32'(bus.clock_change_mode), (k <= 33) ? 32'h1 : 32'h0);
            chk("frame_bit",   32'(bus.clock_max_count),
                (k >= 2 && k <= 33) ? 32'(val[k-2]) : 32'h0);
            chk("frame_done",  32'(bus.done),      (k == 34) ? 32'h1 : 32'h0);
            chk("frame_ready", 32'(bus.cfg_ready), (k == last_k) ? 32'h1 : 32'h0);
            chk("frame_busy",  32'(bus.busy),      (k == last_k) ? 32'h0 : 32'h1);
            if (k >= 2 && k <= 33) recon[k-2] = bus.clock_max_count;
            if (k < last_k) @(negedge fastClk);
        end
        chk("frame_value", recon, val);
        $display("tx value=%h received=%h", val, recon);
    endtask

    initial begin
        bus.cfg_data  = 32'h0;
        bus.cfg_valid = 1'b0;

        // Reset state, then 100 idle cycles with valid low.
        #1;
        chk_idle("reset");
        repeat (3) @(negedge fastClk);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge fastClk);
            chk_idle("idle");
        end
        $display("reset/idle done");

        // Single frame.
        send(32'h0000_0005, 1'b0, 1'b0, 32'h0);
        @(negedge fastClk);

        // Back-to-back with valid held: second acceptance is exactly at T+36.
        send(32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        send(32'h8000_0001, 1'b0, 1'b0, 32'h0);
        @(negedge fastClk);

        // Reset during bit 10 of a frame.
        wait_accept(32'hA5A5_A5A5);
        @(negedge fastClk);
        bus.cfg_valid = 1'b0;
        repeat (11) @(negedge fastClk);
        chk("mid_mode", 32'(bus.clock_change_mode), 32'h1);
        chk("mid_bit",  32'(bus.clock_max_count),   32'h1);
        rst = 1'b0;
        #1;
        chk_idle("mid_reset");
        last_sent_m = 32'h0;
        $display("tx value=a5a5a5a5 aborted by reset");
        @(negedge fastClk);
        rst = 1'b1;
        @(negedge fastClk);
        send(32'h0000_0003, 1'b0, 1'b0, 32'h0);
        @(negedge fastClk);

        // Same value twice: second one is skipped only when the option is built in.
        send(32'h0000_0010, 1'b0, 1'b0, 32'h0);
        @(negedge fastClk);
        send(32'h0000_0010, 1'b0, 1'b0, 32'h0);
        @(negedge fastClk);

        // Input data changed mid-frame must not affect the serialised value.
        send(32'h0000_0007, 1'b0, 1'b1, 32'h0000_0009);
        @(negedge fastClk);

        // Randomized values with random idle spacing and random mid-frame data noise.
        for (int n = 0; n < 8; n++) begin
            int idle;
            idle = $urandom_range(0, 3);
            for (int j = 0; j < idle; j++) begin
                @(negedge fastClk);
                chk_idle("rand_idle");
            end
            send($urandom, 1'b0, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
